// File: rtl/divider_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | divider_seq_ctrl_if : request/result bundle for the sequenced divider |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface divider_seq_ctrl_if #(
   parameter int DW = 8
);
   logic            START;
   logic [2*DW-1:0] DIVIDEND;
   logic [DW-1:0]   DIVISOR;
   logic            BUSY;
   logic            DONE;
   logic [DW-1:0]   QUOTIENT;
   logic [DW-1:0]   REMAINDER;
   logic            DZ;
   logic            DO;

   modport master (
      output START, DIVIDEND, DIVISOR,
      input  BUSY, DONE, QUOTIENT, REMAINDER, DZ, DO
   );

   modport slave (
      input  START, DIVIDEND, DIVISOR,
      output BUSY, DONE, QUOTIENT, REMAINDER, DZ, DO
   );
endinterface
`default_nettype wire

// File: rtl/divider_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | divider_seq_ctrl : 2*DW-by-DW restoring divider, screened and sequenced |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module divider_seq_ctrl #(
   parameter int DW = 8
) (
   input  logic               CLK_1ms,
   input  logic               RST,
   divider_seq_ctrl_if.slave  bus
);
   localparam int            CW   = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ITER  = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t          state;
   logic [2*DW-1:0] dvd;
   logic [DW-1:0]   dvs;
   logic [DW-1:0]   rem;
   logic [DW-1:0]   quo;
   logic [CW-1:0]   cnt;

   logic [DW:0]     trial;
   logic            qbit;
   logic [DW-1:0]   rem_next;

   // The held remainder is always below the divisor, so its top bit is implicitly zero;
   // only the trial value needs the extra bit.
   always_comb begin
      trial    = {rem, dvd[DW-1]};
      qbit     = (trial >= {1'b0, dvs});
      rem_next = qbit ? DW'(trial - {1'b0, dvs}) : trial[DW-1:0];
   end

   always_ff @(posedge CLK_1ms) begin
      if (RST) begin
         state         <= IDLE;
         dvd           <= '0;
         dvs           <= '0;
         rem           <= '0;
         quo           <= '0;
         cnt           <= '0;
         bus.BUSY      <= 1'b0;
         bus.DONE      <= 1'b0;
         bus.QUOTIENT  <= '0;
         bus.REMAINDER <= '0;
         bus.DZ        <= 1'b0;
         bus.DO        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.DONE <= 1'b0;
               bus.BUSY <= 1'b0;
               if (bus.START) begin
                  dvd      <= bus.DIVIDEND;
                  dvs      <= bus.DIVISOR;
                  bus.DZ   <= 1'b0;
                  bus.DO   <= 1'b0;
                  bus.BUSY <= 1'b1;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (dvs == '0) begin
                  bus.DZ        <= 1'b1;
                  bus.DO        <= 1'b0;
                  bus.QUOTIENT  <= '1;
                  bus.REMAINDER <= '0;
                  bus.DONE      <= 1'b1;
                  state         <= FIN;
               end else if (dvd[2*DW-1:DW] >= dvs) begin
                  bus.DZ        <= 1'b0;
                  bus.DO        <= 1'b1;
                  bus.QUOTIENT  <= '1;
                  bus.REMAINDER <= '0;
                  bus.DONE      <= 1'b1;
                  state         <= FIN;
               end else begin
                  rem   <= dvd[2*DW-1:DW];
                  quo   <= '0;
                  cnt   <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               rem          <= rem_next;
               quo          <= {quo[DW-2:0], qbit};
               dvd[DW-1:0]  <= {dvd[DW-2:0], 1'b0};
               cnt          <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bus.QUOTIENT  <= {quo[DW-2:0], qbit};
                  bus.REMAINDER <= rem_next;
                  bus.DONE      <= 1'b1;
                  state         <= FIN;
               end
            end
            FIN: begin
               bus.DONE <= 1'b0;
               bus.BUSY <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_divider_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_divider_seq_ctrl : directed vectors against a cycle-count divide model |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_divider_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_vec  = 0;
   int   n_fail = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   divider_seq_ctrl_if #(.DW(8)) bus ();

   divider_seq_ctrl #(.DW(8)) dut (
      .CLK_1ms (clk),
      .RST     (rst),
      .bus     (bus.slave)
   );

   // Model: results come from plain / and %, timing from a cycle count since acceptance.
   logic       m_busy, m_done, m_dz, m_do;
   logic [7:0] m_q, m_r;
   logic [7:0] p_q, p_r;
   logic       p_dz, p_do;
   int         lat = 0;
   int         fin = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_dz = 0; m_do = 0; m_q = 0; m_r = 0; lat = 0;
      end else if (lat == 0) begin
         m_done = 0;
         if (bus.START) begin
            int a, b;
            a = int'(bus.DIVIDEND);
            b = int'(bus.DIVISOR);
            p_dz = 0; p_do = 0;
            if (b == 0) begin
               p_dz = 1; p_q = 8'hFF; p_r = 8'h00; fin = 2;
            end else if (a / b > 255) begin
               p_do = 1; p_q = 8'hFF; p_r = 8'h00; fin = 2;
            end else begin
               p_q = 8'(a / b); p_r = 8'(a % b); fin = 10;
            end
            lat = 1; m_busy = 1; m_dz = 0; m_do = 0;
         end
      end else if (lat == fin) begin
         m_busy = 0; m_done = 0; lat = 0;
      end else begin
         lat++;
         if (lat == fin) begin
            m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz; m_do = p_do;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en)
         check("cycle_outputs",
               32'({bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DZ, bus.DO}),
               32'({m_busy, m_done, m_q, m_r, m_dz, m_do}));
   end

   task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic edo, input int elat);
      int got;
      got = 0;
      @(negedge clk);
      bus.START = 1'b1; bus.DIVIDEND = a; bus.DIVISOR = b;
      @(negedge clk);
      bus.START = 1'b0; bus.DIVIDEND = 16'hA5A5; bus.DIVISOR = 8'h03;
      for (int c = 1; c <= 20; c++) begin
         if (bus.DONE) begin
            got = c;
            break;
         end
         @(negedge clk);
      end
      check("done_latency", 32'(got), 32'(elat));
      check("quotient", 32'(bus.QUOTIENT), 32'(eq));
      check("remainder", 32'(bus.REMAINDER), 32'(er));
      check("dz_do", 32'({bus.DZ, bus.DO}), 32'({edz, edo}));
      check("busy_at_done", 32'(bus.BUSY), 32'd1);
      check("model_result", 32'({m_q, m_r, m_dz, m_do}), 32'({eq, er, edz, edo}));
   endtask

   initial begin
      int ndone, first;
      rst = 1'b1;
      bus.START = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
      repeat (3) @(negedge clk);
      check("reset_state",
            32'({bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DZ, bus.DO}), 32'd0);
      chk_en = 1'b1;
      rst = 1'b0;

      run_op(16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 10);
      run_op(16'h07FF, 8'd8,   8'd255, 8'd7,   1'b0, 1'b0, 10);
      run_op(16'hFEFF, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 10);
      run_op(16'h1234, 8'd0,   8'hFF,  8'h00,  1'b1, 1'b0, 2);
      run_op(16'd100,  8'd10,  8'd10,  8'd0,   1'b0, 1'b0, 10);
      run_op(16'h0800, 8'd8,   8'hFF,  8'h00,  1'b0, 1'b1, 2);
      run_op(16'hFFFF, 8'd255, 8'hFF,  8'h00,  1'b0, 1'b1, 2);

      // A second request mid-operation must be dropped.
      @(negedge clk);
      bus.START = 1'b1; bus.DIVIDEND = 16'd1000; bus.DIVISOR = 8'd7;
      @(negedge clk);
      bus.START = 1'b0;
      ndone = 0; first = 0;
      for (int c = 1; c <= 14; c++) begin
         if (bus.DONE) begin
            ndone++;
            if (first == 0) first = c;
         end
         if (c == 3) begin
            bus.START = 1'b1; bus.DIVIDEND = 16'd50; bus.DIVISOR = 8'd5;
         end
         if (c == 4) bus.START = 1'b0;
         @(negedge clk);
      end
      check("busy_start_done_count", 32'(ndone), 32'd1);
      check("busy_start_done_cycle", 32'(first), 32'd10);
      check("busy_start_result", 32'({bus.QUOTIENT, bus.REMAINDER}), 32'({8'd142, 8'd6}));

      // Reset lands on the edge that would begin cycle 5.
      bus.START = 1'b1; bus.DIVIDEND = 16'd1000; bus.DIVISOR = 8'd7;
      @(negedge clk);
      bus.START = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midop_reset",
            32'({bus.BUSY, bus.DONE, bus.QUOTIENT, bus.REMAINDER, bus.DZ, bus.DO}), 32'd0);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.DONE) ndone++;
         @(negedge clk);
      end
      check("midop_no_done", 32'(ndone), 32'd0);
      run_op(16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 10);

      // START held high on the error path: results every 3 cycles.
      @(negedge clk);
      bus.START = 1'b1; bus.DIVIDEND = 16'd5; bus.DIVISOR = 8'd0;
      @(negedge clk);
      ndone = 0; first = 0;
      for (int c = 1; c <= 8; c++) begin
         if (bus.DONE) begin
            ndone++;
            first = c;
         end
         if (c < 8) @(negedge clk);
      end
      bus.START = 1'b0;
      check("b2b_done_count", 32'(ndone), 32'd3);
      check("b2b_last_done", 32'(first), 32'd8);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
